// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencing control: fetch/decode/execute/memory/writeback FSM
// with a latched instruction register, branch resolution and a sticky trap.
module multicycle_control_unit #(
    parameter int          XLEN           = 32,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_IR       = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [31:0]     ir,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [1:0]      alu_a_sel,
    output logic            alu_src,
    output logic [3:0]      alu_ctrl,
    output logic            reg_write,
    output logic [1:0]      wb_sel,
    output logic            pc_write,
    output logic [1:0]      pc_sel,
    output logic            instr_retired,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [2:0]      state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t        cur_state, nxt_state;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic [1:0]    cause_nxt;
    logic [31:0]   ir_q;
    logic          ir_load;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rd_nz;
    logic       illegal;
    logic       taken;
    logic [3:0] alu_fn;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign rd_nz  = (ir_q[11:7] != 5'd0);
    assign ir     = ir_q;
    assign state  = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= S_FETCH;
            ir_q       <= RESET_IR;
            wait_cnt   <= '0;
            trap_cause <= 2'd0;
        end else begin
            cur_state  <= nxt_state;
            wait_cnt   <= wait_nxt;
            trap_cause <= cause_nxt;
            if (ir_load)
                ir_q <= imem_rdata;
        end
    end

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OP_R:      illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            OP_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OP_JALR:   illegal = (funct3 != 3'b000);
            OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_LUI, OP_AUIPC: illegal = 1'b0;
            default:   illegal = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (rs1_data == rs2_data);
            3'b001:  taken = (rs1_data != rs2_data);
            3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  taken = (rs1_data <  rs2_data);
            3'b111:  taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
    end

    // SUB exists only for register-register ops; SRA for both R and I shifts.
    always_comb begin
        alu_fn = 4'b0000;
        case (funct3)
            3'b000:  alu_fn = (opcode == OP_R && funct7[5]) ? 4'b0001 : 4'b0000;
            3'b001:  alu_fn = 4'b0111;
            3'b010:  alu_fn = 4'b0101;
            3'b011:  alu_fn = 4'b0110;
            3'b100:  alu_fn = 4'b0100;
            3'b101:  alu_fn = funct7[5] ? 4'b1001 : 4'b1000;
            3'b110:  alu_fn = 4'b0011;
            default: alu_fn = 4'b0010;
        endcase
    end

    always_comb begin
        nxt_state     = cur_state;
        wait_nxt      = '0;
        cause_nxt     = trap_cause;
        ir_load       = 1'b0;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        alu_a_sel     = 2'd0;
        alu_src       = 1'b0;
        alu_ctrl      = 4'b0000;
        reg_write     = 1'b0;
        wb_sel        = 2'd0;
        pc_write      = 1'b0;
        pc_sel        = 2'd0;
        instr_retired = 1'b0;
        trap          = 1'b0;

        case (cur_state)
            S_FETCH: begin
                imem_req = rst_n;
                if (imem_ready) begin
                    ir_load   = 1'b1;
                    nxt_state = S_DECODE;
                end else if (wait_cnt == TMO_LIMIT) begin
                    nxt_state = S_TRAP;
                    cause_nxt = 2'd2;
                end else begin
                    wait_nxt = wait_cnt + CW'(1);
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    nxt_state = S_TRAP;
                    cause_nxt = 2'd1;
                end else begin
                    nxt_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_ctrl  = alu_fn;
                        nxt_state = S_WB;
                    end
                    OP_I: begin
                        alu_src   = 1'b1;
                        alu_ctrl  = alu_fn;
                        nxt_state = S_WB;
                    end
                    OP_LUI, OP_AUIPC: begin
                        alu_a_sel = (opcode == OP_LUI) ? 2'd2 : 2'd1;
                        alu_src   = 1'b1;
                        nxt_state = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src   = 1'b1;
                        nxt_state = S_MEM;
                    end
                    OP_BRANCH: begin
                        pc_write      = 1'b1;
                        pc_sel        = taken ? 2'd1 : 2'd0;
                        instr_retired = 1'b1;
                        nxt_state     = S_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        reg_write     = rd_nz;
                        wb_sel        = 2'd2;
                        pc_write      = 1'b1;
                        pc_sel        = (opcode == OP_JAL) ? 2'd1 : 2'd2;
                        instr_retired = 1'b1;
                        nxt_state     = S_FETCH;
                    end
                    default: begin
                        nxt_state = S_TRAP;
                        cause_nxt = 2'd1;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        nxt_state     = S_FETCH;
                    end else begin
                        nxt_state = S_WB;
                    end
                end else if (wait_cnt == TMO_LIMIT) begin
                    nxt_state = S_TRAP;
                    cause_nxt = 2'd3;
                end else begin
                    wait_nxt = wait_cnt + CW'(1);
                end
            end
            S_WB: begin
                reg_write     = rd_nz;
                wb_sel        = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                nxt_state     = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                nxt_state = S_TRAP;
            end
        endcase
    end

endmodule
